// File: rtl/native_sram_ctrl_pkg.sv
// Shared types and constants for the native-interface SRAM controller.
package native_sram_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Byte-address to word-address shift for 32-bit words
    localparam int unsigned BYTE_OFF = 2;

    // Supported SRAM read-latency range and the counter wide enough for it
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 8;
    localparam int unsigned LAT_CNT_W = $clog2(MAX_READ_LATENCY);

endpackage

// File: rtl/native_sram_ctrl.sv
// Native-interface slave driving a single-port synchronous SRAM macro with a
// fixed read latency. Converts byte addresses to word addresses, inserts wait
// states for reads, and raises a sticky error on out-of-range requests.
module native_sram_ctrl
    import native_sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned MEM_ADDR_W   = 12,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  native_valid,
    output logic                  native_ready,
    input  logic [ADDR_WIDTH-1:0] native_addr,
    input  logic [DATA_WIDTH-1:0] native_wdata,
    input  logic [STRB_WIDTH-1:0] native_wstrb,
    output logic [DATA_WIDTH-1:0] native_rdata,
    output logic                  sram_en,
    output logic [STRB_WIDTH-1:0] sram_we,
    output logic [MEM_ADDR_W-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  err
);

    if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("native_sram_ctrl: READ_LATENCY must be in 1..8");
    end

    state_t                r_state;
    logic [LAT_CNT_W-1:0]  r_cnt;
    logic                  r_is_write;
    logic                  r_oor;
    logic                  r_native_ready;
    logic [DATA_WIDTH-1:0] r_native_rdata;
    logic                  r_sram_en;
    logic [STRB_WIDTH-1:0] r_sram_we;
    logic [MEM_ADDR_W-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_sram_wdata;
    logic                  r_err;

    logic                  w_oor;
    logic [MEM_ADDR_W-1:0] w_word_addr;
    logic                  w_unused_addr_lsb;

    // Address decode: word index and out-of-range detection on the upper bits
    assign w_word_addr       = native_addr[MEM_ADDR_W+BYTE_OFF-1:BYTE_OFF];
    assign w_oor             = |(native_addr >> (MEM_ADDR_W + BYTE_OFF));
    assign w_unused_addr_lsb = ^native_addr[BYTE_OFF-1:0];

    // Controller FSM with registered native and SRAM outputs.
    // The SRAM strobes are loaded on the IDLE->ACCESS edge so that, being
    // registered, they are visible exactly during the ACCESS cycle; this also
    // serves as the latch of the request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_is_write     <= 1'b0;
            r_oor          <= 1'b0;
            r_native_ready <= 1'b0;
            r_native_rdata <= '0;
            r_sram_en      <= 1'b0;
            r_sram_we      <= '0;
            r_sram_addr    <= '0;
            r_sram_wdata   <= '0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_native_ready <= 1'b0;
                    if (native_valid) begin
                        r_is_write   <= |native_wstrb;
                        r_oor        <= w_oor;
                        r_sram_en    <= ~w_oor;
                        r_sram_we    <= w_oor ? '0 : native_wstrb;
                        r_sram_addr  <= w_word_addr;
                        r_sram_wdata <= native_wdata;
                        if (w_oor) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_sram_en <= 1'b0;
                    r_sram_we <= '0;
                    if (r_is_write) begin
                        r_native_ready <= 1'b1;
                        r_state        <= RESP;
                    end else begin
                        r_cnt   <= LAT_CNT_W'(READ_LATENCY - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_native_rdata <= r_oor ? '0 : sram_rdata;
                        r_native_ready <= 1'b1;
                        r_state        <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_native_ready <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign native_ready = r_native_ready;
    assign native_rdata = r_native_rdata;
    assign sram_en      = r_sram_en;
    assign sram_we      = r_sram_we;
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_sram_wdata;
    assign err          = r_err;

endmodule

// File: tb/tb_native_sram_ctrl.sv
// Scoreboard testbench for native_sram_ctrl with a behavioural SRAM macro and
// a word-array reference model of memory contents.
module tb_native_sram_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int MW = 12;
    localparam int RL = 4;

    logic          clk;
    logic          rst;
    logic          native_valid;
    logic          native_ready;
    logic [AW-1:0] native_addr;
    logic [DW-1:0] native_wdata;
    logic [SW-1:0] native_wstrb;
    logic [DW-1:0] native_rdata;
    logic          sram_en;
    logic [SW-1:0] sram_we;
    logic [MW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          err;

    native_sram_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STRB_WIDTH  (SW),
        .MEM_ADDR_W  (MW),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .native_valid(native_valid),
        .native_ready(native_ready),
        .native_addr (native_addr),
        .native_wdata(native_wdata),
        .native_wstrb(native_wstrb),
        .native_rdata(native_rdata),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro: byte-writable array, read data valid RL cycles after sram_en
    logic [DW-1:0] sram_mem [0:(1<<MW)-1];
    logic [DW-1:0] rd_pipe  [RL];
    logic          rd_vld   [RL];
    logic [DW-1:0] junk;

    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < SW; b++)
                if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= sram_mem[sram_addr];
        rd_vld[0]  <= sram_en && (sram_we == '0);
        for (int i = 1; i < RL; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
        junk <= $urandom;
    end
    assign sram_rdata = rd_vld[RL-1] ? rd_pipe[RL-1] : junk;

    // Reference model and scoreboards
    logic [DW-1:0] ref_mem [16];
    logic          exp_err;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int unsigned due;
    } rsp_t;

    typedef struct {
        logic [MW-1:0] addr;
        logic [SW-1:0] we;
        logic [DW-1:0] wdata;
        int unsigned   due;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every ready pulse and every SRAM strobe against the queues
    logic [DW-1:0] exp_rd = '0;
    initial begin
        rsp_t r;
        acc_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rd = '0;
            end else begin
                if (native_ready) begin
                    if (rsp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_ready: native_ready=1 at cycle %0d, required 0", cyc);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("ready_cycle", 64'(cyc), 64'(r.due));
                        if (r.is_rd) begin
                            chk("read_data", native_rdata, r.data);
                            exp_rd = r.data;
                        end else begin
                            chk("rdata_after_write", native_rdata, exp_rd);
                        end
                    end
                end else begin
                    chk("rdata_hold", native_rdata, exp_rd);
                end
                if (sram_en) begin
                    if (acc_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_sram_en: sram_en=1 addr 0x%0h at cycle %0d, required 0", sram_addr, cyc);
                    end else begin
                        a = acc_q.pop_front();
                        chk("sram_cycle", 64'(cyc), 64'(a.due));
                        chk("sram_addr", sram_addr, a.addr);
                        chk("sram_we", sram_we, a.we);
                        if (a.we != '0) chk("sram_wdata", sram_wdata, a.wdata);
                    end
                end
            end
        end
    end

    // Issue one request at a negedge with the DUT idle and wait for completion
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        int unsigned   c;
        bit            oor;
        logic [MW-1:0] w;
        rsp_t          r;
        acc_t          a;
        int            k;
        c   = cyc;
        oor = (addr >> (MW + 2)) != 0;
        w   = addr[MW+1:2];
        native_valid = 1'b1;
        native_addr  = addr;
        native_wdata = wd;
        native_wstrb = st;
        r.is_rd = (st == 4'h0);
        r.due   = c + 2 + (r.is_rd ? RL : 0);
        r.data  = '0;
        if (r.is_rd) begin
            r.data = oor ? 32'h0 : ref_mem[w[3:0]];
        end else if (!oor) begin
            for (int b = 0; b < SW; b++)
                if (st[b]) ref_mem[w[3:0]][8*b +: 8] = wd[8*b +: 8];
        end
        rsp_q.push_back(r);
        if (!oor) begin
            a.addr = w; a.we = st; a.wdata = wd; a.due = c + 1;
            acc_q.push_back(a);
        end else begin
            exp_err = 1'b1;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!native_ready && k < 40);
        if (!native_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: addr 0x%0h got no native_ready in %0d cycles, required at cycle %0d", addr, k, r.due);
        end
        native_valid = 1'b0;
        chk("err", err, exp_err);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rs;
        int unsigned c;
        acc_t        a;
        rst          = 1'b1;
        native_valid = 1'b0;
        native_addr  = '0;
        native_wdata = '0;
        native_wstrb = '0;
        exp_err      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", native_ready, 0);
        chk("rst_rdata", native_rdata, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill the test window so every later read has a defined expectation
        for (int i = 0; i < 16; i++) do_req(32'(i) << 2, $urandom, 4'hF);

        // Directed: full write, read back, byte merge, read back
        do_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        do_req(32'h0000_0010, 32'h0, 4'h0);
        do_req(32'h0000_0010, 32'h0000_AB00, 4'h2);
        do_req(32'h0000_0012, 32'h0, 4'h0);

        // Out-of-range read, then err must stay set across further accesses
        do_req(32'h0001_0000, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) do_req(32'(i) << 2, $urandom, (i % 2 == 0) ? 4'h0 : 4'hF);

        // Reset in WAIT of a read aborts it: SRAM access happened, no ready follows
        c = cyc;
        native_valid = 1'b1;
        native_addr  = 32'h0000_0008;
        native_wstrb = 4'h0;
        a.addr = 12'd2; a.we = 4'h0; a.wdata = '0; a.due = c + 1;
        acc_q.push_back(a);
        repeat (3) @(negedge clk);
        rst          = 1'b1;
        native_valid = 1'b0;
        exp_err      = 1'b0;
        @(negedge clk);
        chk("abort_ready", native_ready, 0);
        chk("abort_rdata", native_rdata, 0);
        chk("abort_sram_en", sram_en, 0);
        chk("abort_sram_we", sram_we, 0);
        chk("abort_sram_addr", sram_addr, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_req(32'h0000_0020, 32'h1234_5678, 4'hF);
        do_req(32'h0000_0020, 32'h0, 4'h0);

        // Randomised alternating writes and reads, occasionally out of range
        for (int i = 0; i < 24; i++) begin
            ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = $urandom | (32'h1 << $urandom_range(14, 31));
            rs = (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req(ra, $urandom, rs);
        end

        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 0);
        chk("sram_queue_drained", 64'(acc_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion before 2000000");
        $fatal(1);
    end

endmodule
